exec_unit_p: RTL and testbench

EXEC_UNIT_P -- requirements
Module: exec_unit_p

---
 rtl/exec_unit_p.sv | 246 ++++++++++++++++++++++++
 tb/tb_exec_unit_p.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_p.sv
// Single-issue execute unit: ALU, branch resolution and an optional iterative multiplier.
// Latency: 1 cycle for all ops; MUL takes WIDTH+1 cycles when EXEC_UNIT_P_MUL_EN is defined.
// Backpressure: valid/ready on both sides; results hold while out_ready=0, flush overrides everything.
//
// Optional feature macro: EXEC_UNIT_P_MUL_EN
//   defined   -> op 14 runs a shift-add multiplier (busy for WIDTH cycles)
//   undefined -> op 14 completes in one cycle with result 0 and ofl 1; busy is tied low
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operation handshake
//   op, a, b, imm,       opcode, operands, sign-extended immediate,
//   pc_inc, use_imm,     incremented PC, immediate select,
//   br_type              branch kind (0 none, 1 BEQZ, 2 BNEZ, 3 BLTZ, 4 BGEZ, 5 JMP, 6 JR)
//   flush                drop in-flight work and refuse new work this cycle
//   out_valid/out_ready  result handshake
//   result, new_pc,      registered result and next PC,
//   taken, ofl           branch taken, signed overflow
//   busy                 multiplier iterating
module exec_unit_p #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc_inc,
  input  logic             use_imm,
  input  logic [2:0]       br_type,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] new_pc,
  output logic             taken,
  output logic             ofl,
  output logic             busy
);

  localparam int SW  = $clog2(WIDTH);
  localparam int HW  = WIDTH / 2;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] new_pc_q, new_pc_d;
  logic             taken_q, taken_d;
  logic             ofl_q, ofl_d;

  logic [WIDTH-1:0] bp;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] sum, diff, btr, alu_res;
  logic             cout, alu_ofl;
  logic             br_tk;
  logic [WIDTH-1:0] br_pc;

  logic             accept, is_mul, single_acc, mul_done;
  logic [WIDTH-1:0] mul_res, mul_pc;
  logic             mul_tk;

  assign bp          = use_imm ? imm : b;
  assign sh          = bp[SW-1:0];
  assign {cout, sum} = {1'b0, a} + {1'b0, bp};
  assign diff        = a - bp;

  always_comb begin
    btr = '0;
    for (int i = 0; i < WIDTH; i++) btr[i] = a[MSB-i];
  end

  // Rotates combine two shifts; a shift by WIDTH (sh == 0) yields zero, so the
  // rotate degenerates cleanly to the unshifted operand.
  always_comb begin
    alu_res = '0;
    alu_ofl = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum;
        alu_ofl = (a[MSB] == bp[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ofl = (a[MSB] != bp[MSB]) && (diff[MSB] != a[MSB]);
      end
      4'd2:  alu_res = a ^ bp;
      4'd3:  alu_res = a & ~bp;
      4'd4:  alu_res = (a << sh) | (a >> (WIDTH - int'(sh)));
      4'd5:  alu_res = a << sh;
      4'd6:  alu_res = (a >> sh) | (a << (WIDTH - int'(sh)));
      4'd7:  alu_res = a >> sh;
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, a == bp};
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <  $signed(bp)};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(bp)};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, cout};
      4'd12: alu_res = btr;
      4'd13: alu_res = {a[HW-1:0], bp[HW-1:0]};
      4'd14: begin
`ifdef EXEC_UNIT_P_MUL_EN
        alu_ofl = 1'b0;
`else
        alu_ofl = 1'b1;
`endif
      end
      default: alu_res = bp;
    endcase
  end

  always_comb begin
    case (br_type)
      3'd1:       br_tk = (a == '0);
      3'd2:       br_tk = (a != '0);
      3'd3:       br_tk = a[MSB];
      3'd4:       br_tk = !a[MSB];
      3'd5, 3'd6: br_tk = 1'b1;
      default:    br_tk = 1'b0;
    endcase
    if (br_type == 3'd6)  br_pc = a + imm;
    else if (br_tk)       br_pc = pc_inc + imm;
    else                  br_pc = pc_inc;
  end

  assign in_ready   = !busy && (!out_valid_q || out_ready) && !flush;
  assign accept     = in_valid && in_ready;
  assign single_acc = accept && !is_mul;

`ifdef EXEC_UNIT_P_MUL_EN
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mpc_q, mpc_d;
  logic             mtk_q, mtk_d;
  logic [WIDTH-1:0] acc_step;

  assign is_mul   = (op == 4'd14);
  assign busy     = (cnt_q != '0);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The last iteration's partial sum goes straight into the result register.
  assign mul_done = (cnt_q == CW'(1)) && !flush;
  assign mul_res  = acc_step;
  assign mul_tk   = mtk_q;
  assign mul_pc   = mpc_q;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mtk_d    = mtk_q;
    mpc_d    = mpc_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && is_mul) begin
      cnt_d    = CW'(WIDTH);
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = bp;
      mtk_d    = br_tk;
      mpc_d    = br_pc;
    end else if (busy) begin
      cnt_d    = cnt_q - CW'(1);
      acc_d    = acc_step;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mtk_q    <= 1'b0;
      mpc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mtk_q    <= mtk_d;
      mpc_q    <= mpc_d;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_tk   = 1'b0;
  assign mul_pc   = '0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    new_pc_d    = new_pc_q;
    taken_d     = taken_q;
    ofl_d       = ofl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (single_acc) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      new_pc_d    = br_pc;
      taken_d     = br_tk;
      ofl_d       = alu_ofl;
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_res;
      new_pc_d    = mul_pc;
      taken_d     = mul_tk;
      ofl_d       = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      new_pc_q    <= '0;
      taken_q     <= 1'b0;
      ofl_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      new_pc_q    <= new_pc_d;
      taken_q     <= taken_d;
      ofl_q       <= ofl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign new_pc    = new_pc_q;
  assign taken     = taken_q;
  assign ofl       = ofl_q;

endmodule

// File: tb/tb_exec_unit_p.sv
// Self-checking bench for exec_unit_p at WIDTH=16: directed vectors, random ops
// against a plain-arithmetic reference model, backpressure, flush and reset abort.
// Works with or without EXEC_UNIT_P_MUL_EN defined.
module tb_exec_unit_p;
  localparam int W = 16;
`ifdef EXEC_UNIT_P_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0, imm = '0, pc_inc = '0;
  logic          use_imm = 1'b0;
  logic [2:0]    br_type = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result, new_pc;
  logic          taken, ofl, busy;

  int n_checks = 0;
  int n_fail   = 0;

  exec_unit_p #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .imm(imm), .pc_inc(pc_inc), .use_imm(use_imm),
    .br_type(br_type), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .new_pc(new_pc), .taken(taken), .ofl(ofl), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: {result, ofl, taken, new_pc}, from the arithmetic definition of each op.
  function automatic logic [33:0] model(input logic [3:0] o, input logic [15:0] ia, ib, iimm,
                                        input logic [15:0] ipc, input logic iui, input logic [2:0] bt);
    logic [15:0] bsel;
    int unsigned ua, ub, r, np;
    int sa, sb, sh;
    logic ov, t;
    bsel = iui ? iimm : ib;
    ua = ia; ub = bsel;
    sa = int'($signed(ia)); sb = int'($signed(bsel));
    sh = int'(ub % 16);
    ov = 1'b0; r = 0;
    case (o)
      4'd0:  begin r = ua + ub; ov = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1:  begin r = ua - ub; ov = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2:  r = ua ^ ub;
      4'd3:  r = ua & ~ub;
      4'd4:  r = (ua << sh) | (ua >> (16 - sh));
      4'd5:  r = ua << sh;
      4'd6:  r = (ua >> sh) | (ua << (16 - sh));
      4'd7:  r = ua >> sh;
      4'd8:  r = (ua == ub) ? 1 : 0;
      4'd9:  r = (sa < sb) ? 1 : 0;
      4'd10: r = (sa <= sb) ? 1 : 0;
      4'd11: r = (ua + ub) >> 16;
      4'd12: for (int i = 0; i < 16; i++) r = r | (((ua >> i) & 1) << (15 - i));
      4'd13: r = (ua << 8) | (ub & 255);
      4'd14: begin r = MUL_EN ? ua * ub : 0; ov = !MUL_EN; end
      default: r = ub;
    endcase
    case (bt)
      3'd1: t = (ua == 0);
      3'd2: t = (ua != 0);
      3'd3: t = (sa < 0);
      3'd4: t = (sa >= 0);
      3'd5, 3'd6: t = 1'b1;
      default: t = 1'b0;
    endcase
    if (bt == 3'd6) np = ua + iimm;
    else if (t)     np = ipc + iimm;
    else            np = ipc;
    return {r[15:0], ov, t, np[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Present one op, wait (bounded) for its result; returns latency and outputs.
  task automatic issue(input logic [3:0] o, input logic [15:0] ia, ib, iimm, ipc,
                       input logic iui, input logic [2:0] bt,
                       output int lat, output logic [33:0] got);
    @(negedge clk);
    op = o; a = ia; b = ib; imm = iimm; pc_inc = ipc; use_imm = iui; br_type = bt;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    got = {result, ofl, taken, new_pc};
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({out_valid, busy, taken, ofl, result, new_pc} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b busy=%b tk=%b ofl=%b res=%h pc=%h, want all 0",
               out_valid, busy, taken, ofl, result, new_pc);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int lat;
    logic [33:0] got;
    logic [33:0] exp_t [6];
    string nm [6];
    logic [3:0] ops [6] = '{4'd0, 4'd6, 4'd12, 4'd0, 4'd0, 4'd5};
    logic [15:0] as [6] = '{16'h7FFF, 16'h0001, 16'h0001, 16'hFFFE, 16'h0002, 16'h0001};
    logic [15:0] bs [6] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] is [6] = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFC, 16'hFFFC, 16'h000F};
    logic        us [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  bt [6] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd0};
    exp_t[0] = {16'h8000, 1'b1, 1'b0, 16'h0010}; nm[0] = "add_ovf";
    exp_t[1] = {16'h8000, 1'b0, 1'b0, 16'h0010}; nm[1] = "ror1";
    exp_t[2] = {16'h8000, 1'b0, 1'b0, 16'h0010}; nm[2] = "btr";
    exp_t[3] = {16'hFFFE, 1'b0, 1'b1, 16'h000C}; nm[3] = "bltz_taken";
    exp_t[4] = {16'h0002, 1'b0, 1'b0, 16'h0010}; nm[4] = "bltz_not";
    exp_t[5] = {16'h8000, 1'b0, 1'b0, 16'h0010}; nm[5] = "sll15";
    for (int k = 0; k < 6; k++) begin
      issue(ops[k], as[k], bs[k], is[k], 16'h0010, us[k], bt[k], lat, got);
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d want 1", nm[k], lat);
      end
      n_checks++;
      if (got !== exp_t[k]) begin
        n_fail++;
        $display("FAIL %s: got res/ofl/tk/pc=%h want %h", nm[k], got, exp_t[k]);
      end
    end
  endtask

  task automatic test_mul();
    int lat, busy_cnt, rdy_bad;
    logic [33:0] exp_m;
    exp_m = MUL_EN ? {16'h03A8, 1'b0, 1'b0, 16'h0040} : {16'h0000, 1'b1, 1'b0, 16'h0040};
    @(negedge clk);
    op = 4'd14; a = 16'h0012; b = 16'h0034; imm = '0; pc_inc = 16'h0040;
    use_imm = 1'b0; br_type = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; busy_cnt = 0; rdy_bad = 0;
    while (!out_valid && lat < 64) begin
      if (busy) busy_cnt++;
      if (busy && in_ready) rdy_bad++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (busy_cnt !== (MUL_EN ? 16 : 0)) begin
      n_fail++;
      $display("FAIL mul_busy_cycles: got %0d want %0d", busy_cnt, MUL_EN ? 16 : 0);
    end
    n_checks++;
    if (rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL mul_in_ready_while_busy: got %0d cycles ready want 0", rdy_bad);
    end
    n_checks++;
    if (lat !== (MUL_EN ? 17 : 1)) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d want %0d", lat, MUL_EN ? 17 : 1);
    end
    n_checks++;
    if ({result, ofl, taken, new_pc, busy} !== {exp_m, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_result: got %h busy=%b want %h busy=0", {result, ofl, taken, new_pc}, busy, exp_m);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [33:0] got, exp_r;
    logic [3:0] o;
    logic [15:0] ra, rb, ri, rp;
    logic ru;
    logic [2:0] rbt;
    for (int k = 0; k < 160; k++) begin
      o = 4'($urandom_range(0, 15));
      ra = pick(); rb = pick(); ri = pick(); rp = 16'($urandom);
      ru = 1'($urandom_range(0, 1)); rbt = 3'($urandom_range(0, 7));
      exp_r = model(o, ra, rb, ri, rp, ru, rbt);
      issue(o, ra, rb, ri, rp, ru, rbt, lat, got);
      n_checks++;
      if (lat !== ((o == 4'd14 && MUL_EN) ? 17 : 1)) begin
        n_fail++;
        $display("FAIL rand_latency op=%0d: got %0d", o, lat);
      end
      n_checks++;
      if (got !== exp_r) begin
        n_fail++;
        $display("FAIL rand op=%0d a=%h b=%h imm=%h ui=%b bt=%0d: got %h want %h",
                 o, ra, rb, ri, ru, rbt, got, exp_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] na, nb;
    logic [33:0] exp_n;
    @(negedge clk);
    op = 4'd9; a = 16'h8000; b = 16'h0001; use_imm = 1'b0; br_type = 3'd0;
    pc_inc = 16'h0020; imm = '0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 16'h0001}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got ov=%b rdy=%b res=%h want ov=1 rdy=0 res=0001",
                 k, out_valid, in_ready, result);
      end
      if (k < 2) @(negedge clk);
    end
    na = pick(); nb = pick();
    exp_n = model(4'd0, na, nb, 16'h0000, 16'h0030, 1'b0, 3'd0);
    op = 4'd0; a = na; b = nb; pc_inc = 16'h0030; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, ofl, taken, new_pc} !== {1'b1, exp_n}) begin
      n_fail++;
      $display("FAIL b2b_result: got ov=%b %h want ov=1 %h", out_valid,
               {result, ofl, taken, new_pc}, exp_n);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  // Starts a long-lived op (MUL if present, else a held single-cycle result),
  // then aborts it with flush (mode 0) or reset (mode 1).
  task automatic test_abort(input int mode);
    int seen;
    @(negedge clk);
    op = MUL_EN ? 4'd14 : 4'd0; a = 16'h0012; b = 16'h0034; use_imm = 1'b0;
    br_type = 3'd0; in_valid = 1'b1; out_ready = MUL_EN;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    if (mode == 0) begin
      flush = 1'b1; op = 4'd0; in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_in_ready: got %b want 0", in_ready);
      end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
    end else begin
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, busy, result, new_pc, taken, ofl} !== 36'h0) begin
        n_fail++;
        $display("FAIL rst_mid_async: got ov=%b busy=%b res=%h pc=%h want all 0",
                 out_valid, busy, result, new_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
      end
    end
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort%0d_state: got ov=%b busy=%b want 0 0", mode, out_valid, busy);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort%0d_no_result: got %0d cycles with activity want 0", mode, seen);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_random();
    test_back_to_back();
    test_abort(0);
    test_abort(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
